// File: rtl/acc_pkg.sv
// Shared definitions for the edge-detection accelerator memory responder.
// Contents: image geometry constants, default image/result placement,
// word/halfword types, the acc_mem FSM state enum and an address range helper.
package acc_pkg;

    localparam int IMG_W_PX  = 352;
    localparam int IMG_H_PX  = 288;
    // Four 8-bit pixels are packed into each 32-bit word.
    localparam int IMG_WORDS = (IMG_W_PX * IMG_H_PX) / 4;
    // Results are placed directly after the input image.
    localparam int OUT_BASE  = IMG_WORDS;

    typedef logic [31:0] word_t;
    typedef logic [15:0] halfword_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DUMP   = 2'd3
    } acc_mem_state_t;

    // True when a 16-bit word address falls inside a RAM of 'depth' words.
    function automatic logic addr_in_range(input halfword_t a, input int depth);
        return ({16'd0, a} < 32'(depth));
    endfunction

endpackage

// File: rtl/acc_mem_ram.sv
// Single-port synchronous RAM, DEPTH x 32 bits.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset (clears rdata only)
//   en          - port enable
//   we          - write (1) / read (0) when enabled
//   addr        - word address
//   wdata       - write data
//   rdata       - registered read data, updated only by enabled reads
// Memory contents are never cleared by reset.
module acc_mem_ram #(
    parameter int DEPTH = 50688,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Storage array: write at the clock edge, no reset so contents persist.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: holds the last read word between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 32'd0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/acc_mem.sv
// Memory responder for the edge-detection accelerator.
// Loads an image from the host stream, pulses start, serves the accelerator's
// single-port word bus until finish, then streams the result region back.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   addr/en/we/dataW    - accelerator request bus (served only in RUN)
//   dataR               - accelerator read data, 1-cycle latency, holds when idle
//   start               - one-cycle pulse after the image load completes
//   finish              - accelerator completion level
//   in_valid/in_ready/in_data    - host load stream
//   out_valid/out_ready/out_data - host dump stream
//   done                - one-cycle pulse after the last dump handshake
//   rd_count/wr_count   - accelerator access statistics
//   err                 - sticky out-of-range access flag
// Configuration macro: ACC_MEM_STATS_EN enables the rd_count/wr_count counters;
// without it both outputs are tied to zero.
module acc_mem #(
    parameter int IMG_WORDS = acc_pkg::IMG_WORDS,
    parameter int OUT_BASE  = acc_pkg::OUT_BASE,
    parameter int DEPTH     = 50688
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] dataW,
    output logic [31:0] dataR,
    output logic        start,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        done,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        err
);

    import acc_pkg::*;

    localparam int        AW         = $clog2(DEPTH);
    localparam halfword_t LAST_IDX   = halfword_t'(IMG_WORDS - 1);
    localparam halfword_t IMG_CNT    = halfword_t'(IMG_WORDS);
    localparam halfword_t OUT_BASE_H = halfword_t'(OUT_BASE);

    acc_mem_state_t state_r;
    acc_mem_state_t state_nxt_s;

    halfword_t ld_cnt_r;
    halfword_t dp_cnt_r;
    halfword_t out_cnt_r;

    logic      acc_req_s;
    logic      acc_ok_s;
    logic      acc_rd_s;
    logic      acc_oor_s;
    logic      load_hs_s;
    logic      load_last_s;
    logic      dump_pop_s;
    logic      dump_last_s;
    logic      dump_issue_s;
    logic [2:0] fifo_after_s;

    logic          ram_en_s;
    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    word_t         ram_wdata_s;
    word_t         ram_rdata_s;

    logic  rd_sel_r;
    logic  rd_zero_r;
    word_t rd_hold_r;
    word_t data_r_s;

    word_t      skid0_r;
    word_t      skid1_r;
    logic [1:0] skid_cnt_r;
    logic       rd_pend_r;

    logic done_r;
    logic err_r;
    logic in_ready_s;
    logic start_s;

    // Request decode for the accelerator, load and dump paths.
    always_comb begin
        acc_req_s    = (state_r == RUN) && en;
        acc_ok_s     = addr_in_range(addr, DEPTH);
        acc_rd_s     = acc_req_s && !we;
        acc_oor_s    = acc_req_s && !acc_ok_s;
        load_hs_s    = (state_r == LOAD) && in_valid;
        load_last_s  = load_hs_s && (ld_cnt_r == LAST_IDX);
        dump_pop_s   = (skid_cnt_r != 2'd0) && out_ready;
        dump_last_s  = dump_pop_s && (out_cnt_r == LAST_IDX);
        // Skid occupancy after this edge if no new read is issued; a read is
        // only issued when its returning word is guaranteed a free slot.
        fifo_after_s = {1'b0, skid_cnt_r} + {2'b00, rd_pend_r} - {2'b00, dump_pop_s};
        dump_issue_s = (state_r == DUMP) && (dp_cnt_r != IMG_CNT) && (fifo_after_s < 3'd2);
    end

    // RAM port ownership follows the FSM state.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = {AW{1'b0}};
        ram_wdata_s = 32'd0;
        case (state_r)
            LOAD: begin
                ram_en_s    = load_hs_s;
                ram_we_s    = 1'b1;
                ram_addr_s  = AW'(ld_cnt_r);
                ram_wdata_s = in_data;
            end
            RUN: begin
                ram_en_s    = acc_req_s && acc_ok_s;
                ram_we_s    = we;
                ram_addr_s  = AW'(addr);
                ram_wdata_s = dataW;
            end
            DUMP: begin
                ram_en_s    = dump_issue_s;
                ram_we_s    = 1'b0;
                ram_addr_s  = AW'(OUT_BASE_H + dp_cnt_r);
                ram_wdata_s = 32'd0;
            end
            default: begin
                ram_en_s    = 1'b0;
                ram_we_s    = 1'b0;
                ram_addr_s  = {AW{1'b0}};
                ram_wdata_s = 32'd0;
            end
        endcase
    end

    acc_mem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (load_last_s) begin
                    state_nxt_s = LAUNCH;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            LAUNCH: state_nxt_s = RUN;
            RUN: begin
                if (finish) begin
                    state_nxt_s = DUMP;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DUMP: begin
                if (dump_last_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = DUMP;
                end
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // FSM outputs, decoded straight from the state register.
    always_comb begin
        in_ready_s = 1'b0;
        start_s    = 1'b0;
        case (state_r)
            LOAD:    in_ready_s = 1'b1;
            LAUNCH:  start_s    = 1'b1;
            default: begin
                in_ready_s = 1'b0;
                start_s    = 1'b0;
            end
        endcase
    end

    // Load, dump-issue and dump-handshake counters plus done/err flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt_r  <= 16'd0;
            dp_cnt_r  <= 16'd0;
            out_cnt_r <= 16'd0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= dump_last_s;
            err_r  <= err_r | acc_oor_s;
            if (load_last_s) begin
                ld_cnt_r <= 16'd0;
            end else if (load_hs_s) begin
                ld_cnt_r <= ld_cnt_r + 16'd1;
            end
            if (dump_last_s) begin
                dp_cnt_r <= 16'd0;
            end else if (dump_issue_s) begin
                dp_cnt_r <= dp_cnt_r + 16'd1;
            end
            if (dump_last_s) begin
                out_cnt_r <= 16'd0;
            end else if (dump_pop_s) begin
                out_cnt_r <= out_cnt_r + 16'd1;
            end
        end
    end

    // Accelerator read-return tracking. The RAM read register is shared with
    // the dump path, so dataR shows it only in the cycle right after an
    // accelerator read and otherwise replays the captured copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sel_r  <= 1'b0;
            rd_zero_r <= 1'b0;
            rd_hold_r <= 32'd0;
        end else begin
            rd_sel_r  <= acc_rd_s && acc_ok_s;
            rd_zero_r <= acc_rd_s && !acc_ok_s;
            rd_hold_r <= data_r_s;
        end
    end

    // dataR source select: fresh RAM word, zero for out-of-range, or held value.
    always_comb begin
        if (rd_sel_r) begin
            data_r_s = ram_rdata_s;
        end else if (rd_zero_r) begin
            data_r_s = 32'd0;
        end else begin
            data_r_s = rd_hold_r;
        end
    end

    // Two-entry skid buffer for dump words; skid0_r is always the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_r  <= 1'b0;
            skid0_r    <= 32'd0;
            skid1_r    <= 32'd0;
            skid_cnt_r <= 2'd0;
        end else begin
            rd_pend_r <= dump_issue_s;
            case ({rd_pend_r, dump_pop_s})
                2'b10: begin
                    if (skid_cnt_r == 2'd0) begin
                        skid0_r <= ram_rdata_s;
                    end else begin
                        skid1_r <= ram_rdata_s;
                    end
                    skid_cnt_r <= skid_cnt_r + 2'd1;
                end
                2'b01: begin
                    skid0_r    <= skid1_r;
                    skid_cnt_r <= skid_cnt_r - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt_r == 2'd1) begin
                        skid0_r <= ram_rdata_s;
                    end else begin
                        skid0_r <= skid1_r;
                        skid1_r <= ram_rdata_s;
                    end
                end
                default: begin
                    skid_cnt_r <= skid_cnt_r;
                end
            endcase
        end
    end

`ifdef ACC_MEM_STATS_EN
    logic [31:0] rd_count_r;
    logic [31:0] wr_count_r;

    // Served accelerator access counters, out-of-range accesses included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_r <= 32'd0;
            wr_count_r <= 32'd0;
        end else begin
            if (acc_rd_s) begin
                rd_count_r <= rd_count_r + 32'd1;
            end
            if (acc_req_s && we) begin
                wr_count_r <= wr_count_r + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

    assign dataR     = data_r_s;
    assign start     = start_s;
    assign in_ready  = in_ready_s;
    assign out_valid = (skid_cnt_r != 2'd0);
    assign out_data  = skid0_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
